excp_irq_agent: RTL and testbench

- Consumer end of the machine-level interrupt lines: takes the level timer interrupt from the timer block, plus the software and external interrupt lines.
- Resynchronises the lines, applies CSR enables and fixed priority, and runs a req/ack handshake with the commit stage to take the trap at an instruction boundary.
- Supplies mcause/mepc/mip to the CSR unit, then masks further interrupts until mret.
- Sits in the excp unit between the interrupt sources and the pipeline commit/CSR logic.

---
 rtl/excp_irq_agent_pkg.sv | 35 +++
 rtl/excp_irq_sync.sv | 24 ++
 rtl/excp_irq_agent.sv | 161 ++++++++++++++++
 tb/tb_excp_irq_agent.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/excp_irq_agent_pkg.sv
// Shared constants, state encoding and priority helper for the machine-level
// interrupt agent of the excp unit.
package excp_irq_agent_pkg;

  localparam logic [3:0] IRQ_CAUSE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CAUSE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CAUSE_MEI = 4'd11;

  localparam int MIE_MSIE_BIT = 3;
  localparam int MIE_MTIE_BIT = 7;
  localparam int MIE_MEIE_BIT = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    TAKEN   = 2'd2,
    HANDLER = 2'd3
  } irq_state_e;

  // Fixed priority MEI > MSI > MTI; returns 0 when nothing is pending.
  function automatic logic [3:0] irq_prio_cause(input logic mei, input logic msi, input logic mti);
    logic [3:0] cause;
    if (mei) begin
      cause = IRQ_CAUSE_MEI;
    end else if (msi) begin
      cause = IRQ_CAUSE_MSI;
    end else if (mti) begin
      cause = IRQ_CAUSE_MTI;
    end else begin
      cause = 4'd0;
    end
    return cause;
  endfunction

endpackage

// File: rtl/excp_irq_sync.sv
// Multi-flop level synchroniser with synchronous active-high reset.
module excp_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/excp_irq_agent.sv
// Machine-level interrupt agent: synchronises irq lines, applies enables and
// priority, and hands one trap at a time to the commit stage.
module excp_irq_agent
  import excp_irq_agent_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tmr_irq_i,
  input  logic            ext_irq_i,
  input  logic            sw_irq_i,
  input  logic            csr_mstatus_mie_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            irq_ack_i,
  input  logic            mret_i,
  output logic            irq_req_o,
  output logic [3:0]      irq_cause_o,
  output logic            csr_wr_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mip_o,
  output logic            in_handler_o
);

  // A single flop is not a synchroniser, so shallower settings are clamped.
  localparam int STAGES_C = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic            tmr_sync_s;
  logic            ext_sync_s;
  logic            sw_sync_r;
  logic [XLEN-1:0] mip_s;
  logic            pend_msi_s;
  logic            pend_mti_s;
  logic            pend_mei_s;
  logic            any_pend_s;
  logic            cause_pend_s;
  logic [3:0]      next_cause_s;
  logic            unused_mie_s;

  irq_state_e      state_r;
  logic            irq_req_r;
  logic [3:0]      irq_cause_r;
  logic            csr_wr_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mepc_r;
  logic            in_handler_r;

  excp_irq_sync #(.STAGES(STAGES_C)) u_tmr_sync (
    .clk (clk),
    .rst (rst),
    .d   (tmr_irq_i),
    .q   (tmr_sync_s)
  );

  excp_irq_sync #(.STAGES(STAGES_C)) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq_i),
    .q   (ext_sync_s)
  );

  // msip is already in the clk domain; one register stage aligns it with mip.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync_r <= 1'b0;
    end else begin
      sw_sync_r <= sw_irq_i;
    end
  end

  // Assemble mip from the synchronised levels; all other bits read zero.
  always_comb begin
    mip_s               = {XLEN{1'b0}};
    mip_s[MIE_MSIE_BIT] = sw_sync_r;
    mip_s[MIE_MTIE_BIT] = tmr_sync_s;
    mip_s[MIE_MEIE_BIT] = ext_sync_s;
  end

  assign unused_mie_s = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:4], csr_mie_i[2:0]};

  // Per-source pending, winning cause, and whether the latched cause is still live.
  always_comb begin
    pend_msi_s   = sw_sync_r  & csr_mie_i[MIE_MSIE_BIT] & csr_mstatus_mie_i;
    pend_mti_s   = tmr_sync_s & csr_mie_i[MIE_MTIE_BIT] & csr_mstatus_mie_i;
    pend_mei_s   = ext_sync_s & csr_mie_i[MIE_MEIE_BIT] & csr_mstatus_mie_i;
    any_pend_s   = pend_msi_s | pend_mti_s | pend_mei_s;
    next_cause_s = irq_prio_cause(pend_mei_s, pend_msi_s, pend_mti_s);
    case (irq_cause_r)
      IRQ_CAUSE_MSI: cause_pend_s = pend_msi_s;
      IRQ_CAUSE_MTI: cause_pend_s = pend_mti_s;
      IRQ_CAUSE_MEI: cause_pend_s = pend_mei_s;
      default:       cause_pend_s = 1'b0;
    endcase
  end

  // Trap handshake FSM; every output it drives is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      irq_req_r    <= 1'b0;
      irq_cause_r  <= 4'd0;
      csr_wr_r     <= 1'b0;
      mcause_r     <= {XLEN{1'b0}};
      mepc_r       <= {XLEN{1'b0}};
      in_handler_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          csr_wr_r <= 1'b0;
          if (any_pend_s && !in_handler_r) begin
            state_r     <= REQ;
            irq_req_r   <= 1'b1;
            irq_cause_r <= next_cause_s;
            mcause_r    <= {1'b1, {(XLEN-5){1'b0}}, next_cause_s};
          end
        end
        REQ: begin
          // Ack beats a simultaneous withdrawal of the latched cause.
          if (irq_ack_i && irq_req_r) begin
            state_r      <= TAKEN;
            irq_req_r    <= 1'b0;
            csr_wr_r     <= 1'b1;
            mepc_r       <= commit_pc_i;
            in_handler_r <= 1'b1;
          end else if (!cause_pend_s) begin
            state_r   <= IDLE;
            irq_req_r <= 1'b0;
          end
        end
        TAKEN: begin
          state_r  <= HANDLER;
          csr_wr_r <= 1'b0;
        end
        HANDLER: begin
          if (mret_i) begin
            state_r      <= IDLE;
            in_handler_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          irq_req_r    <= 1'b0;
          csr_wr_r     <= 1'b0;
          in_handler_r <= 1'b0;
        end
      endcase
    end
  end

  assign mip_o        = mip_s;
  assign irq_req_o    = irq_req_r;
  assign irq_cause_o  = irq_cause_r;
  assign csr_wr_o     = csr_wr_r;
  assign mcause_o     = mcause_r;
  assign mepc_o       = mepc_r;
  assign in_handler_o = in_handler_r;

endmodule

// File: tb/tb_excp_irq_agent.sv
// Randomised and directed bench for excp_irq_agent against a behavioural trap model.
module tb_excp_irq_agent;

  localparam int XLEN = 32;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            tmr, ext, sw, mstatus, ack, mret;
  logic [XLEN-1:0] mie, pc;
  logic            irq_req, csr_wr, in_handler;
  logic [3:0]      irq_cause;
  logic [XLEN-1:0] mcause, mepc, mip;

  int total = 0;
  int bad   = 0;

  // model of the architectural behaviour
  bit          m_req, m_csr_wr, m_in_h;
  int          m_cause;
  logic [31:0] m_mcause, m_mepc, m_mip;
  bit          tq[$];
  bit          eq[$];

  excp_irq_agent #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk               (clk),
    .rst               (rst),
    .tmr_irq_i         (tmr),
    .ext_irq_i         (ext),
    .sw_irq_i          (sw),
    .csr_mstatus_mie_i (mstatus),
    .csr_mie_i         (mie),
    .commit_pc_i       (pc),
    .irq_ack_i         (ack),
    .mret_i            (mret),
    .irq_req_o         (irq_req),
    .irq_cause_o       (irq_cause),
    .csr_wr_o          (csr_wr),
    .mcause_o          (mcause),
    .mepc_o            (mepc),
    .mip_o             (mip),
    .in_handler_o      (in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_csr_wr = 0; m_in_h = 0; m_cause = 0;
    m_mcause = 32'h0; m_mepc = 32'h0; m_mip = 32'h0;
    tq = {}; eq = {};
    for (int i = 0; i < SYNC - 1; i++) begin
      tq.push_back(1'b0);
      eq.push_back(1'b0);
    end
  endtask

  // One clock edge of the reference: what the agent must do given current inputs.
  task automatic model_step();
    logic [31:0] pend_v;
    int          prio[3];
    bit          found;
    prio = '{11, 3, 7};
    if (rst) begin
      model_reset();
      return;
    end
    pend_v = m_mip & mie & {32{mstatus}};
    if (m_csr_wr) begin
      m_csr_wr = 0;
    end else if (m_in_h) begin
      if (mret) m_in_h = 0;
    end else if (m_req) begin
      if (ack) begin
        m_mepc = pc; m_req = 0; m_csr_wr = 1; m_in_h = 1;
      end else if (!pend_v[m_cause]) begin
        m_req = 0;
      end
    end else begin
      found = 0;
      foreach (prio[i]) begin
        if (!found && pend_v[prio[i]]) begin
          found = 1;
          m_cause = prio[i];
          m_req = 1;
          m_mcause = 32'h8000_0000 | 32'(m_cause);
        end
      end
    end
    tq.push_front(tmr);
    eq.push_front(ext);
    m_mip = 32'h0;
    m_mip[7]  = tq.pop_back();
    m_mip[11] = eq.pop_back();
    m_mip[3]  = sw;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("req",    {31'd0, irq_req},    {31'd0, m_req});
    chk("cause",  {28'd0, irq_cause},  32'(m_cause));
    chk("csr_wr", {31'd0, csr_wr},     {31'd0, m_csr_wr});
    chk("mcause", mcause,              m_mcause);
    chk("mepc",   mepc,                m_mepc);
    chk("mip",    mip,                 m_mip);
    chk("in_h",   {31'd0, in_handler}, {31'd0, m_in_h});
  endtask

  initial begin
    rst = 1'b1; tmr = 1'b0; ext = 1'b0; sw = 1'b0; mstatus = 1'b0;
    ack = 1'b0; mret = 1'b0; mie = 32'h0; pc = 32'h0;
    model_reset();
    step(); step();
    chk("rst_req", {31'd0, irq_req}, 32'd0);
    chk("rst_mcause", mcause, 32'h0);
    rst = 1'b0;

    // timer request latency and cause
    mie = 32'h80; mstatus = 1'b1; tmr = 1'b1;
    step(); step();
    chk("tmr_req_early", {31'd0, irq_req}, 32'd0);
    chk("tmr_mip", mip, 32'h80);
    step();
    chk("tmr_req", {31'd0, irq_req}, 32'd1);
    chk("tmr_cause", {28'd0, irq_cause}, 32'd7);
    chk("tmr_mcause", mcause, 32'h8000_0007);

    // ack -> trap entry
    pc = 32'h120; ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_csr_wr", {31'd0, csr_wr}, 32'd1);
    chk("ack_mepc", mepc, 32'h120);
    chk("ack_in_h", {31'd0, in_handler}, 32'd1);
    step();
    chk("csr_wr_once", {31'd0, csr_wr}, 32'd0);

    // handler masks, mret reopens
    step(); step();
    chk("hdl_masked", {31'd0, irq_req}, 32'd0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("mret_in_h", {31'd0, in_handler}, 32'd0);
    chk("mret_req", {31'd0, irq_req}, 32'd0);
    step();
    chk("rereq", {31'd0, irq_req}, 32'd1);

    // higher source in REQ leaves cause frozen, then withdraw
    ext = 1'b1; mie = 32'h880;
    step(); step(); step(); step();
    chk("frozen", {28'd0, irq_cause}, 32'd7);
    mie = 32'h800;
    step();
    chk("withdraw", {31'd0, irq_req}, 32'd0);
    chk("withdraw_wr", {31'd0, csr_wr}, 32'd0);
    step();
    chk("mei_req", {28'd0, irq_cause}, 32'd11);

    // ack in the same cycle the enable drops
    mie = 32'h0; ack = 1'b1; pc = 32'h200;
    step();
    ack = 1'b0;
    chk("ack_wins", {31'd0, csr_wr}, 32'd1);
    chk("ack_wins_mepc", mepc, 32'h200);
    step();
    mret = 1'b1; step(); mret = 1'b0;
    mret = 1'b1; step(); mret = 1'b0;
    chk("mret_idle", {31'd0, in_handler}, 32'd0);

    // simultaneous pending: MEI wins
    mstatus = 1'b0; mie = 32'h888; sw = 1'b1;
    step(); step(); step();
    mstatus = 1'b1;
    step();
    chk("prio_mei", {28'd0, irq_cause}, 32'd11);

    // reset during REQ and during TAKEN
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_in_req", {31'd0, irq_req}, 32'd0);
    chk("rst_in_req_mip", mip, 32'h0);
    step(); step(); step();
    chk("req_after_rst", {31'd0, irq_req}, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_in_taken_wr", {31'd0, csr_wr}, 32'd0);
    chk("rst_in_taken_h", {31'd0, in_handler}, 32'd0);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) tmr = ~tmr;
      if ($urandom_range(0, 15) == 0) ext = ~ext;
      if ($urandom_range(0, 15) == 0) sw  = ~sw;
      if ($urandom_range(0, 49) == 0) mstatus = ~mstatus;
      if ($urandom_range(0, 29) == 0) mie = $urandom();
      ack  = ($urandom_range(0, 2) == 0);
      mret = ($urandom_range(0, 3) == 0);
      pc   = $urandom();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
